// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Start/busy/done handshake; result saturates to all nines when it does not fit.
//
// state    | meaning
// ST_IDLE  | waiting for start; result registers hold the last conversion
// ST_SHIFT | adjust digits >=5 by +3, then shift {scratch,bin} left, DATA_W times
// ST_DONE  | publish result (or saturate), pulse done, drop busy
module bin_to_bcd_seq #(
   parameter int DATA_W = 14,
   parameter int DIGITS = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     data_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SCR_W = 4 * (DIGITS + 1);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  bin_q, bin_d;
   logic [SCR_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               spill_q, spill_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               ovf_q, ovf_d;

   logic [SCR_W-1:0]   scratch_adj;
   logic               digit_gt9;
   logic               saturate;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         bin_q     <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         spill_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         spill_q   <= spill_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
      end
   end

   // All digits, guard included, are corrected in parallel before the shift.
   always_comb begin
      scratch_adj = scratch_q;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      digit_gt9 = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] > 4'd9) begin
            digit_gt9 = 1'b1;
         end
      end
   end

   // spill catches a bit shifted out of the guard digit on oversized DATA_W/DIGITS combos.
   assign saturate = spill_q || (scratch_q[SCR_W-1 -: 4] != 4'd0) || digit_gt9;

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      spill_d   = spill_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bin_d     = data_in;
               scratch_d = '0;
               cnt_d     = '0;
               spill_d   = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            scratch_d = {scratch_adj[SCR_W-2:0], bin_q[DATA_W-1]};
            spill_d   = spill_q | scratch_adj[SCR_W-1];
            bin_d     = bin_q << 1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            if (saturate) begin
               bcd_d = {DIGITS{4'h9}};
               ovf_d = 1'b1;
            end else begin
               bcd_d = scratch_q[BCD_W-1:0];
               ovf_d = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = ovf_q;

endmodule
